// File: rtl/u_mul_err_mon8_if.sv
// ---------------------------------------------------------------------------
// u_mul_err_mon8_if
// Bundles the sample stream, the result handshake and the window start
// request of the approximate-multiplier error monitor.
//   master : stimulus / consumer side (drives start, in_valid, a, b, approx,
//            out_ready; observes in_ready and the results)
//   slave  : the monitor itself
// Parameter LOG2_N sets the result widths and must match the monitor.
// ---------------------------------------------------------------------------
interface u_mul_err_mon8_if #(
  parameter int unsigned LOG2_N = 8
);
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          a;
  logic [7:0]          b;
  logic [15:0]         approx;
  logic                out_valid;
  logic                out_ready;
  logic [15+LOG2_N:0]  sum_abs_err;
  logic [15:0]         max_err;
  logic [LOG2_N:0]     err_cnt;

  modport master (
    output start, in_valid, a, b, approx, out_ready,
    input  in_ready, out_valid, sum_abs_err, max_err, err_cnt
  );

  modport slave (
    input  start, in_valid, a, b, approx, out_ready,
    output in_ready, out_valid, sum_abs_err, max_err, err_cnt
  );
endinterface

// File: rtl/u_mul_err_mon8.sv
// ---------------------------------------------------------------------------
// u_mul_err_mon8
// Streaming error monitor for an 8x8 unsigned approximate multiplier. Over a
// window of 2^LOG2_N accepted samples it accumulates the sum of absolute
// errors, the largest absolute error and the number of mismatching samples
// against the exact product, then offers them on a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of u_mul_err_mon8_if
//           start            - open a new window (honoured only in IDLE)
//           in_valid/in_ready - sample handshake for a, b, approx
//           out_valid/out_ready - result handshake
//           sum_abs_err, max_err, err_cnt - window statistics
// Pipeline: accept -> P1 (operands) -> P2 (|error|) -> accumulators.
// ---------------------------------------------------------------------------
module u_mul_err_mon8 #(
  parameter int unsigned LOG2_N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  u_mul_err_mon8_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  // Index of the last sample in a window (counter value when it is accepted).
  localparam logic [LOG2_N:0] LAST_IDX = (LOG2_N+1)'((64'd1 << LOG2_N) - 64'd1);

  // |a*b - approx|; the 17-bit difference always has a 16-bit magnitude.
  function automatic logic [15:0] abs_err16(
    input logic [7:0]  op_a,
    input logic [7:0]  op_b,
    input logic [15:0] approx_v
  );
    logic [15:0] exact_v;
    logic [16:0] diff_v;
    logic [16:0] neg_v;
    exact_v = op_a * op_b;
    diff_v  = {1'b0, exact_v} - {1'b0, approx_v};
    neg_v   = 17'd0 - diff_v;
    if (diff_v[16]) begin
      abs_err16 = neg_v[15:0];
    end else begin
      abs_err16 = diff_v[15:0];
    end
  endfunction

  state_t               state_r;
  state_t               state_nx_s;

  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [LOG2_N:0]      smp_cnt_r;

  logic                 p1_valid_r;
  logic [7:0]           p1_a_r;
  logic [7:0]           p1_b_r;
  logic [15:0]          p1_approx_r;

  logic                 p2_valid_r;
  logic [15:0]          p2_diff_r;
  logic                 p2_mis_r;

  logic [15+LOG2_N:0]   sum_r;
  logic [15:0]          max_r;
  logic [LOG2_N:0]      cnt_r;

  logic                 accept_s;
  logic                 last_s;
  logic                 clear_s;

  assign accept_s = bus.in_valid & in_ready_r;
  assign last_s   = accept_s & (smp_cnt_r == LAST_IDX);
  assign clear_s  = (state_r == S_IDLE) & bus.start;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic. DRAIN leaves once P1 is empty: P2 then holds the
  // final sample, which is accumulated on the same edge REPORT is entered.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_nx_s = S_DRAIN;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!p1_valid_r) begin
          state_nx_s = S_REPORT;
        end else begin
          state_nx_s = S_DRAIN;
        end
      end
      S_REPORT: begin
        if (out_valid_r && bus.out_ready) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_REPORT;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Registered handshake outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx_s == S_RUN);
      out_valid_r <= (state_nx_s == S_REPORT);
    end
  end

  // Sample counter: cleared on start, advanced on every accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_r <= '0;
    end else if (clear_s) begin
      smp_cnt_r <= '0;
    end else if (accept_s) begin
      smp_cnt_r <= smp_cnt_r + {{LOG2_N{1'b0}}, 1'b1};
    end else begin
      smp_cnt_r <= smp_cnt_r;
    end
  end

  // P1: capture accepted operands; an empty slot follows every bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid_r  <= 1'b0;
      p1_a_r      <= 8'd0;
      p1_b_r      <= 8'd0;
      p1_approx_r <= 16'd0;
    end else begin
      p1_valid_r <= accept_s;
      if (accept_s) begin
        p1_a_r      <= bus.a;
        p1_b_r      <= bus.b;
        p1_approx_r <= bus.approx;
      end else begin
        p1_a_r      <= p1_a_r;
        p1_b_r      <= p1_b_r;
        p1_approx_r <= p1_approx_r;
      end
    end
  end

  // P2: absolute error and mismatch flag of the P1 sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_valid_r <= 1'b0;
      p2_diff_r  <= 16'd0;
      p2_mis_r   <= 1'b0;
    end else begin
      p2_valid_r <= p1_valid_r;
      if (p1_valid_r) begin
        p2_diff_r <= abs_err16(p1_a_r, p1_b_r, p1_approx_r);
        p2_mis_r  <= (abs_err16(p1_a_r, p1_b_r, p1_approx_r) != 16'd0);
      end else begin
        p2_diff_r <= p2_diff_r;
        p2_mis_r  <= p2_mis_r;
      end
    end
  end

  // Statistics accumulators; they hold their result until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      max_r <= 16'd0;
      cnt_r <= '0;
    end else if (clear_s) begin
      sum_r <= '0;
      max_r <= 16'd0;
      cnt_r <= '0;
    end else if (p2_valid_r) begin
      sum_r <= sum_r + {{LOG2_N{1'b0}}, p2_diff_r};
      if (p2_diff_r > max_r) begin
        max_r <= p2_diff_r;
      end else begin
        max_r <= max_r;
      end
      cnt_r <= cnt_r + {{LOG2_N{1'b0}}, p2_mis_r};
    end else begin
      sum_r <= sum_r;
      max_r <= max_r;
      cnt_r <= cnt_r;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.sum_abs_err = sum_r;
  assign bus.max_err     = max_r;
  assign bus.err_cnt     = cnt_r;

endmodule
